// File: rtl/switch_ctrl_seq.sv
// switch_ctrl_seq: frame sequencer for a column of NUM_SW 2x2 switches.
//
// A frame is requested with start while idle; stage and sw_mask are latched on that edge.
// During the frame a beat counter walks 0..FRAME_LEN-1, and every enabled switch swaps when
// the latched stage bit of the counter is 1. A one-cycle drain follows the last beat so that
// the final registered beat (out_valid) lines up with done.
//
// Optional feature: define SWCTRL_STALL_EN to let in_valid=0 stall the frame (counter and
// ctrl hold). Without it every RUN cycle is a beat and in_valid is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      frame request, honoured only when idle
//   stage      counter bit index that drives swapping (latched on start)
//   sw_mask    per-switch enable (latched on start)
//   in_valid   data beat present at the switch inputs
//   ctrl       per-switch select, 0 = pass, 1 = swap (from registered state only)
//   out_valid  data beat present at the switch outputs (1 cycle after acceptance)
//   busy       high in RUN and DRAIN
//   done       one-cycle end-of-frame pulse (the DRAIN cycle)
module switch_ctrl_seq #(
    parameter int unsigned NUM_SW    = 16,
    parameter int unsigned FRAME_LEN = 32,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned STG_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STG_W-1:0]  stage,
    input  logic [NUM_SW-1:0] sw_mask,
    input  logic              in_valid,
    output logic [NUM_SW-1:0] ctrl,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(FRAME_LEN - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [NUM_SW-1:0] mask_q, mask_d;
    logic              out_valid_q;
    logic              beat;
    logic              sel_bit;

`ifdef SWCTRL_STALL_EN
    assign beat = (state_q == StRun) && in_valid;
`else
    // Every RUN cycle is a beat; in_valid has no effect in this build.
    logic unused_in_valid;
    assign unused_in_valid = in_valid;
    assign beat = (state_q == StRun);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        mask_d  = mask_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    stage_d = stage;
                    mask_d  = sw_mask;
                end
            end
            StRun: begin
                if (beat) begin
                    // FRAME_LEN is a power of two, so the increment wraps to 0 on the last beat.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stage_q     <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            mask_q      <= mask_d;
            out_valid_q <= beat;
        end
    end

    // Select cnt[stage_q]; a stage at or beyond CNT_W matches nothing and yields 0 (all pass).
    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < int'(CNT_W); i++) begin
            if (int'(stage_q) == i) begin
                sel_bit = cnt_q[i];
            end
        end
    end

    always_comb begin
        ctrl = '0;
        if (state_q == StRun) begin
            ctrl = {NUM_SW{sel_bit}} & mask_q;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDrain);

endmodule

// File: tb/tb_switch_ctrl_seq.sv
// Directed bench for switch_ctrl_seq (default parameters). Inputs change 1 ns after each
// rising edge; outputs are sampled at the same point, i.e. they show the state after that edge.
module tb_switch_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  stage;
    logic [15:0] sw_mask;
    logic        in_valid;
    logic [15:0] ctrl;
    logic        out_valid;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    switch_ctrl_seq #(
        .NUM_SW   (16),
        .FRAME_LEN(32),
        .CNT_W    (5),
        .STG_W    (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stage    (stage),
        .sw_mask  (sw_mask),
        .in_valid (in_valid),
        .ctrl     (ctrl),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_ctrl(input int k, input int stg, input logic [15:0] msk);
        if (stg >= 5) return 16'h0000;
        return ((k >> stg) & 1) != 0 ? msk : 16'h0000;
    endfunction

    // Full frame with in_valid held high; starts from IDLE, ends back in IDLE.
    task automatic run_frame(input logic [2:0] stg, input logic [15:0] msk);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        start = 1'b1; stage = stg; sw_mask = msk; in_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check_eq("run_ctrl", ctrl, exp_ctrl(k, int'(stg), msk));
            check_eq("run_ov", out_valid, (k > 0) ? 1 : 0);
            busy_cnt += busy ? 1 : 0;
            done_cnt += done ? 1 : 0;
            tick();
        end
        check_eq("drain_done", done, 1);
        check_eq("drain_ov", out_valid, 1);
        check_eq("drain_ctrl", ctrl, 0);
        busy_cnt += busy ? 1 : 0;
        done_cnt += done ? 1 : 0;
        tick();
        check_eq("frame_busy_cycles", busy_cnt, 33);
        check_eq("frame_done_count", done_cnt, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);
        check_eq("idle_ov", out_valid, 0);
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1; start = 1'b0; stage = 3'd0; sw_mask = 16'h0000; in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_ctrl", ctrl, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ov", out_valid, 0);

        // in_valid outside RUN must not create out_valid.
        in_valid = 1'b1;
        tick();
        check_eq("idle_inval_ov", out_valid, 0);

        // Alternating pattern, then stage 2 with half mask.
        run_frame(3'd0, 16'hFFFF);
        run_frame(3'd2, 16'h00FF);

        // start during RUN (with a different stage) and during DRAIN is ignored.
        done_cnt = 0;
        start = 1'b1; stage = 3'd0; sw_mask = 16'hFFFF; in_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check_eq("ign_ctrl", ctrl, exp_ctrl(k, 0, 16'hFFFF));
            done_cnt += done ? 1 : 0;
            if (k == 10) begin
                start = 1'b1; stage = 3'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check_eq("ign_drain_done", done, 1);
        done_cnt += done ? 1 : 0;
        start = 1'b1;
        tick();
        check_eq("ign_after_drain_busy", busy, 0);
        check_eq("ign_done_count", done_cnt, 1);
        tick();
        // start seen in IDLE: new frame with stage 1 latched.
        start = 1'b0;
        check_eq("restart_busy", busy, 1);
        for (int k = 0; k < 21; k++) begin
            check_eq("restart_ctrl", ctrl, exp_ctrl(k, 1, 16'hFFFF));
            if (k < 20) tick();
        end

        // Reset at beat 20, together with start: reset wins, frame abandoned.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check_eq("midrst_ctrl", ctrl, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ov", out_valid, 0);
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            done_cnt += done ? 1 : 0;
            tick();
        end
        check_eq("midrst_no_done", done_cnt, 0);
        check_eq("midrst_stay_idle", busy, 0);

        // stage beyond counter width: all switches pass.
        run_frame(3'd7, 16'hFFFF);

`ifdef SWCTRL_STALL_EN
        // in_valid low at RUN cycles 5..7: counter holds, done 3 cycles later.
        begin
            int cnt_m;
            int prev_acc;
            int cyc;
            cnt_m = 0; prev_acc = 0; cyc = 0;
            start = 1'b1; stage = 3'd0; sw_mask = 16'hFFFF; in_valid = 1'b1;
            tick();
            start = 1'b0;
            while (cnt_m < 32 && cyc < 40) begin
                in_valid = (cyc >= 5 && cyc <= 7) ? 1'b0 : 1'b1;
                check_eq("stall_ctrl", ctrl, exp_ctrl(cnt_m, 0, 16'hFFFF));
                check_eq("stall_ov", out_valid, prev_acc);
                check_eq("stall_done", done, 0);
                prev_acc = in_valid ? 1 : 0;
                if (in_valid) cnt_m++;
                cyc++;
                tick();
            end
            check_eq("stall_run_cycles", cyc, 35);
            check_eq("stall_drain_done", done, 1);
            check_eq("stall_drain_ov", out_valid, 1);
            in_valid = 1'b1;
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
